// File: rtl/flood_ctrl.sv
// flood_ctrl: Flood-It sequencer that owns the flooded-region bitmap and recolours the board RAM in raster passes
module flood_ctrl #(
    parameter int MAX_SIZE = 14,
    parameter int COLOR_W  = 3,
    parameter int ADDR_W   = 8
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic [3:0]         SIZE,
    input  logic               NEW_GAME,
    input  logic               COLOR_VALID,
    input  logic [COLOR_W-1:0] COLOR_SEL,
    output logic               COLOR_ACK,
    output logic [ADDR_W-1:0]  RD_ADDR,
    input  logic [COLOR_W-1:0] RD_DATA,
    output logic               WR_EN,
    output logic [ADDR_W-1:0]  WR_ADDR,
    output logic [COLOR_W-1:0] WR_DATA,
    output logic               BUSY,
    output logic               DONE,
    output logic               WON,
    output logic [7:0]         MOVES,
    output logic [7:0]         FLOODED
);
    localparam int CELLS = MAX_SIZE * MAX_SIZE;

    typedef enum logic [2:0] {IDLE, INIT_RD, INIT_WAIT, SCAN_RD, SCAN_EVAL, PASS_END, FINISH} state_t;

    state_t             state, state_nx;
    logic [CELLS-1:0]   owned;
    logic [3:0]         size, row, col, last;
    logic [COLOR_W-1:0] target, cur;
    logic               changed, ready;
    logic [ADDR_W-1:0]  addr;
    logic               accept, noop, last_cell, nbr, own_here, join_cell;

    assign last      = size - 4'd1;
    assign addr      = ADDR_W'(row) * ADDR_W'(MAX_SIZE) + ADDR_W'(col);
    assign own_here  = owned[addr];
    // each neighbour term is only consulted when that neighbour lies inside the board
    assign nbr       = (row != 4'd0 && owned[addr - ADDR_W'(MAX_SIZE)]) ||
                       (row != last && owned[addr + ADDR_W'(MAX_SIZE)]) ||
                       (col != 4'd0 && owned[addr - ADDR_W'(1)]) ||
                       (col != last && owned[addr + ADDR_W'(1)]);
    assign join_cell = !own_here && RD_DATA == target && nbr;
    assign last_cell = row == last && col == last;
    // no game exists until the first NEW_GAME, so requests wait until then
    assign accept    = state == IDLE && ready && COLOR_VALID && !NEW_GAME;
    assign noop      = WON || COLOR_SEL == cur;

    // State register
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic; a new board pre-empts any operation in progress
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = accept ? (noop ? FINISH : SCAN_RD) : IDLE;
            INIT_RD:   state_nx = INIT_WAIT;
            INIT_WAIT: state_nx = SCAN_RD;
            SCAN_RD:   state_nx = SCAN_EVAL;
            SCAN_EVAL: state_nx = last_cell ? PASS_END : SCAN_RD;
            PASS_END:  state_nx = changed ? SCAN_RD : FINISH;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (NEW_GAME) state_nx = INIT_RD;
    end

    // Outputs decoded from the current state
    always_comb begin
        COLOR_ACK = accept;
        RD_ADDR   = state == SCAN_RD ? addr : '0;
        WR_EN     = state == SCAN_EVAL && (own_here || join_cell);
        WR_ADDR   = WR_EN ? addr : '0;
        WR_DATA   = WR_EN ? target : '0;
        BUSY      = state != IDLE;
        DONE      = state == FINISH;
    end

    // Region bitmap, scan position, colours and score counters
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            owned   <= '0;
            size    <= 4'd2;
            row     <= '0;
            col     <= '0;
            target  <= '0;
            cur     <= '0;
            changed <= 1'b0;
            ready   <= 1'b0;
            WON     <= 1'b0;
            MOVES   <= '0;
            FLOODED <= '0;
        end else if (NEW_GAME) begin
            owned   <= CELLS'(1);
            size    <= SIZE < 4'd2 ? 4'd2 : SIZE > 4'(MAX_SIZE) ? 4'(MAX_SIZE) : SIZE;
            row     <= '0;
            col     <= '0;
            changed <= 1'b0;
            ready   <= 1'b1;
            WON     <= 1'b0;
            MOVES   <= '0;
            FLOODED <= 8'd1;
        end else begin
            if (accept && !noop) begin
                target <= COLOR_SEL;
                if (MOVES != 8'hff) MOVES <= MOVES + 8'd1;
            end
            if (state == INIT_WAIT) begin
                target <= RD_DATA;
                cur    <= RD_DATA;
            end
            if (state == SCAN_EVAL) begin
                if (join_cell) begin
                    owned[addr] <= 1'b1;
                    FLOODED     <= FLOODED + 8'd1;
                    changed     <= 1'b1;
                end
                col <= col == last ? 4'd0 : col + 4'd1;
                row <= last_cell ? 4'd0 : col == last ? row + 4'd1 : row;
            end
            if (state == PASS_END) begin
                changed <= 1'b0;
                if (!changed) begin
                    cur <= target;
                    WON <= FLOODED == 8'(size) * 8'(size);
                end
            end
        end
    end
endmodule

// File: tb/tb_flood_ctrl.sv
// tb_flood_ctrl: directed and random Flood-It games checked against a breadth-first region model
module tb_flood_ctrl;
    localparam int M     = 14;
    localparam int CELLS = M * M;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] size_in = '0;
    logic       new_game = 1'b0;
    logic       color_valid = 1'b0;
    logic [2:0] color_sel = '0;
    logic       color_ack, wr_en, busy, done, won;
    logic [7:0] rd_addr, wr_addr, moves, flooded;
    logic [2:0] rd_data, wr_data;
    logic       load = 1'b0;

    logic [2:0] mem [256];
    logic [2:0] ref_b [CELLS];
    bit         ref_own [CELLS];
    int         n = 2;
    logic [2:0] ref_cur = '0;
    int         ref_moves = 0;
    bit         ref_won = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         wr_cnt = 0;
    int         bad_cnt = 0;
    logic [7:0] rd_max = '0;
    int         snake [16];

    flood_ctrl dut (
        .CLOCK(clk), .RESET_N(rst_n), .SIZE(size_in), .NEW_GAME(new_game),
        .COLOR_VALID(color_valid), .COLOR_SEL(color_sel), .COLOR_ACK(color_ack),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data), .WR_EN(wr_en), .WR_ADDR(wr_addr),
        .WR_DATA(wr_data), .BUSY(busy), .DONE(done), .WON(won), .MOVES(moves),
        .FLOODED(flooded)
    );

    always #5 clk = ~clk;

    // board RAM with one-cycle read latency; a new board is loaded in a single cycle
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (load) for (int i = 0; i < CELLS; i++) mem[i] <= ref_b[i];
        else if (wr_en) mem[wr_addr] <= wr_data;
    end

    // bus monitor: write count, highest read address, any access outside the live board
    always @(negedge clk) begin
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rd_addr > rd_max) rd_max <= rd_addr;
        if (busy && (int'(rd_addr) / M >= n || int'(rd_addr) % M >= n)) bad_cnt <= bad_cnt + 1;
        if (wr_en && (int'(wr_addr) / M >= n || int'(wr_addr) % M >= n)) bad_cnt <= bad_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int own_count();
        int k = 0;
        for (int i = 0; i < CELLS; i++) k += int'(ref_own[i]);
        return k;
    endfunction

    // grow the region over every connected cell of colour c
    task automatic absorb(input logic [2:0] c);
        int q[$];
        int a, r, k, rr, kk;
        for (int i = 0; i < CELLS; i++) if (ref_own[i]) q.push_back(i);
        while (q.size() > 0) begin
            a = q.pop_front();
            r = a / M;
            k = a % M;
            for (int d = 0; d < 4; d++) begin
                rr = r + (d == 0 ? -1 : d == 1 ? 1 : 0);
                kk = k + (d == 2 ? -1 : d == 3 ? 1 : 0);
                if (rr >= 0 && rr < n && kk >= 0 && kk < n) begin
                    if (!ref_own[rr * M + kk] && ref_b[rr * M + kk] == c) begin
                        ref_own[rr * M + kk] = 1'b1;
                        q.push_back(rr * M + kk);
                    end
                end
            end
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < CELLS; i++) ref_own[i] = 1'b0;
        ref_own[0] = 1'b1;
        ref_moves  = 0;
        ref_cur    = ref_b[0];
        absorb(ref_cur);
        ref_won    = own_count() == n * n;
    endtask

    task automatic model_move(input logic [2:0] c);
        if (ref_moves < 255) ref_moves++;
        for (int i = 0; i < CELLS; i++) if (ref_own[i]) ref_b[i] = c;
        absorb(c);
        ref_cur = c;
        ref_won = own_count() == n * n;
    endtask

    task automatic wait_done(output bit found, output int acks);
        found = 1'b0;
        acks  = 0;
        for (int t = 0; t < 30000 && !found; t++) begin
            @(negedge clk);
            acks += int'(color_ack);
            found = done;
        end
    endtask

    task automatic check_state(input string tag);
        int mm = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== ref_b[i]) mm++;
        chk({tag, ".flooded"}, flooded, own_count());
        chk({tag, ".moves"}, moves, ref_moves);
        chk({tag, ".won"}, won, ref_won);
        chk({tag, ".ram_cells_wrong"}, mm, 0);
        chk({tag, ".out_of_board_access"}, bad_cnt, 0);
    endtask

    task automatic game(input logic [3:0] s, input string tag);
        bit found;
        int acks;
        n = s < 4'd2 ? 2 : s > 4'(M) ? M : int'(s);
        model_init();
        size_in  = s;
        new_game = 1'b1;
        load     = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        load     = 1'b0;
        chk({tag, ".start"}, {won, moves, flooded}, {1'b0, 8'd0, 8'd1});
        wait_done(found, acks);
        chk({tag, ".init_done"}, found, 1);
        chk({tag, ".no_ack_in_init"}, acks, 0);
        @(negedge clk);
        chk({tag, ".idle"}, busy, 0);
        check_state(tag);
    endtask

    task automatic do_color(input logic [2:0] c, input string tag);
        bit found, noop, got;
        int acks, w0, t;
        noop        = ref_won || c == ref_cur;
        color_valid = 1'b1;
        color_sel   = c;
        #1;
        t = 0;
        while (!color_ack && t < 30000) begin
            @(negedge clk);
            #1;
            t++;
        end
        got = color_ack;
        chk({tag, ".ack"}, got, 1);
        if (!got) begin
            color_valid = 1'b0;
            return;
        end
        @(negedge clk);
        color_valid = 1'b0;
        w0 = wr_cnt;
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".done_next"}, done, noop);
        if (!noop) begin
            model_move(c);
            wait_done(found, acks);
            chk({tag, ".done"}, found, 1);
        end
        @(negedge clk);
        chk({tag, ".idle"}, busy, 0);
        if (noop) chk({tag, ".no_writes"}, wr_cnt - w0, 0);
        check_state(tag);
    endtask

    initial begin
        int a;
        for (int i = 0; i < CELLS; i++) ref_b[i] = 3'd6;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {color_ack, rd_addr, wr_en, wr_addr, wr_data, busy, done, won, moves, flooded}, 0);
        rst_n = 1'b1;
        color_valid = 1'b1;
        color_sel = 3'd2;
        a = 0;
        repeat (6) begin
            @(negedge clk);
            a += int'(color_ack);
        end
        chk("no_ack_before_game", a, 0);
        color_valid = 1'b0;

        ref_b[0] = 3'd0;
        ref_b[1] = 3'd1;
        ref_b[M] = 3'd1;
        ref_b[M + 1] = 3'd1;
        game(4'd0, "g2");
        do_color(3'd1, "g2.m1");
        chk("g2.m1.fixed", {won, moves, flooded}, {1'b1, 8'd1, 8'd4});
        do_color(3'd2, "g2.after_win");
        chk("g2.after_win.moves", moves, 1);
        chk("g2.rd_max", rd_max <= 8'd15, 1);

        snake = '{0, 3, 1, 3, 1, 3, 1, 3, 1, 3, 3, 3, 2, 2, 2, 2};
        for (int i = 0; i < CELLS; i++) ref_b[i] = 3'd7;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) ref_b[r * M + k] = 3'(snake[r * 4 + k]);
        game(4'd4, "g4");
        do_color(3'd3, "g4.m3");
        chk("g4.m3.region", flooded, 8);
        do_color(3'd5, "g4.m5");
        do_color(3'd5, "g4.repeat5");
        chk("g4.repeat5.moves", moves, 2);
        do_color(3'd1, "g4.m1");
        chk("g4.m1.region", flooded, 12);
        do_color(3'd2, "g4.m2");
        chk("g4.m2.win", {won, flooded}, {1'b1, 8'd16});
        do_color(3'd4, "g4.after_win");

        for (int i = 0; i < CELLS; i++) ref_b[i] = 3'($urandom_range(0, 7));
        game(4'd15, "g14");
        repeat (5) do_color(3'($urandom_range(0, 7)), "g14.rnd");
        chk("g14.rd_max", int'(rd_max) <= CELLS - 1, 1);

        for (int i = 0; i < CELLS; i++) ref_b[i] = 3'd1;
        ref_b[0] = 3'd0;
        game(4'd14, "ab");
        color_valid = 1'b1;
        color_sel = 3'd1;
        @(negedge clk);
        repeat (100) @(negedge clk);
        chk("ab.busy_mid_scan", busy, 1);
        for (int i = 0; i < CELLS; i++) ref_b[i] = 3'($urandom_range(0, 7));
        game(4'd14, "ab.new");
        do_color(3'd1, "ab.held");

        for (int i = 0; i < CELLS; i++) ref_b[i] = 3'd1;
        ref_b[0] = 3'd0;
        game(4'd14, "rs");
        color_valid = 1'b1;
        color_sel = 3'd1;
        @(negedge clk);
        color_valid = 1'b0;
        repeat (500) @(negedge clk);
        chk("rs.busy_pass2", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rs.outputs", {color_ack, rd_addr, wr_en, wr_addr, wr_data, busy, done, won, moves, flooded}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        color_valid = 1'b1;
        a = 0;
        repeat (8) begin
            @(negedge clk);
            a += int'(color_ack);
        end
        chk("rs.no_ack", a, 0);
        color_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
